// File: rtl/corescore_uart_tx.sv
// AXI-Stream byte to UART TX serializer with a one-byte holding register.
// Optional even parity bit (8E1) when CORESCORE_UART_PARITY_EN is defined.
module corescore_uart_tx #(
  parameter int CLKS_PER_BIT = 139
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_tdata,
  input  logic       i_tlast,
  input  logic       i_tvalid,
  output logic       o_tready,
  output logic       o_uart_tx,
  output logic       o_busy,
  output logic       o_frame_done
);

  // state  | meaning
  // IDLE   | line high, waiting for a held byte
  // START  | start bit (0)
  // DATA   | 8 data bits, LSB first
  // PARITY | even parity bit (parity build only)
  // STOP   | stop bit (1); reload from holding register or go idle

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

`ifdef CORESCORE_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          last_q, last_d;
  logic [7:0]    hold_data_q, hold_data_d;
  logic          hold_last_q, hold_last_d;
  logic          hold_valid_q, hold_valid_d;
  logic          tx_q, tx_d;
  logic          tready_q, tready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tick, accept, load;
`ifdef CORESCORE_UART_PARITY_EN
  logic          parity_q, parity_d;
`endif

  assign tick   = (cnt_q == CNT_MAX);
  assign accept = i_tvalid && tready_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    last_d       = last_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    hold_valid_d = hold_valid_q;
    done_d       = 1'b0;
    load         = 1'b0;
`ifdef CORESCORE_UART_PARITY_EN
    parity_d     = parity_q;
`endif

    if (state_q == IDLE) cnt_d = '0;
    else                 cnt_d = tick ? '0 : cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (hold_valid_q) load = 1'b1;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
`ifdef CORESCORE_UART_PARITY_EN
          if (idx_q == 3'd7) state_d = PARITY;
`else
          if (idx_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef CORESCORE_UART_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          done_d = last_q;
          if (hold_valid_q) load = 1'b1;
          else              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d      = START;
      cnt_d        = '0;
      shift_d      = hold_data_q;
      last_d       = hold_last_q;
      hold_valid_d = 1'b0;
`ifdef CORESCORE_UART_PARITY_EN
      parity_d     = ^hold_data_q;
`endif
    end

    // tready is low whenever hold_valid is set, so accept never overlaps load
    if (accept) begin
      hold_data_d  = i_tdata;
      hold_last_d  = i_tlast;
      hold_valid_d = 1'b1;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef CORESCORE_UART_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase

    tready_d = !hold_valid_d;
    busy_d   = hold_valid_d || (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      shift_q      <= 8'd0;
      last_q       <= 1'b0;
      hold_data_q  <= 8'd0;
      hold_last_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
      tready_q     <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef CORESCORE_UART_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      last_q       <= last_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
      tready_q     <= tready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef CORESCORE_UART_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign o_uart_tx    = tx_q;
  assign o_tready     = tready_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_corescore_uart_tx.sv
// Directed self-checking bench for corescore_uart_tx with CLKS_PER_BIT=4.
module tb_corescore_uart_tx;

  localparam int CPB = 4;
`ifdef CORESCORE_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic       tlast = 1'b0;
  logic       tvalid = 1'b0;
  logic       tready, tx, busy, done;

  int checks = 0;
  int errors = 0;

  corescore_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata), .i_tlast(tlast),
    .i_tvalid(tvalid), .o_tready(tready), .o_uart_tx(tx), .o_busy(busy),
    .o_frame_done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bit sequence on the wire, index 0 = start bit
  function automatic logic [10:0] mk(input logic [7:0] d);
`ifdef CORESCORE_UART_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {2'b11, d, 1'b0};
`endif
  endfunction

  task automatic send(input logic [7:0] d, input logic l);
    @(negedge clk);
    chk("tready_idle", {7'd0, tready}, 8'd1);
    tdata = d; tlast = l; tvalid = 1'b1;
    @(posedge clk);
    #1 tvalid = 1'b0;
    @(negedge clk);
    chk("tx_after_accept", {7'd0, tx}, 8'd1);
    chk("tready_held", {7'd0, tready}, 8'd0);
    chk("busy_held", {7'd0, busy}, 8'd1);
  endtask

  task automatic run_frame(input logic [10:0] f);
    for (int i = 0; i < NB; i++)
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        chk("bit", {7'd0, tx}, {7'd0, f[i]});
        chk("busy_frame", {7'd0, busy}, 8'd1);
        chk("done_mid", {7'd0, done}, 8'd0);
      end
  endtask

  task automatic frame_end(input logic l);
    @(negedge clk);
    chk("done_end", {7'd0, done}, {7'd0, l});
    chk("busy_end", {7'd0, busy}, 8'd0);
    chk("tx_end", {7'd0, tx}, 8'd1);
    chk("tready_end", {7'd0, tready}, 8'd1);
    @(negedge clk);
    chk("done_pulse", {7'd0, done}, 8'd0);
  endtask

  logic [10:0] fa, fb;
  logic [21:0] seq;

  initial begin
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_tx", {7'd0, tx}, 8'd1);
      chk("rst_tready", {7'd0, tready}, 8'd1);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_done", {7'd0, done}, 8'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_tx", {7'd0, tx}, 8'd1);

    // 0x55, no tlast
    send(8'h55, 1'b0);
    run_frame(mk(8'h55));
    frame_end(1'b0);

    // back-to-back 0x41, 0x42 with tvalid held
    fa = mk(8'h41);
    fb = mk(8'h42);
    seq = '0;
    for (int i = 0; i < NB; i++) begin
      seq[i] = fa[i];
      seq[NB+i] = fb[i];
    end
    @(negedge clk);
    tdata = 8'h41; tlast = 1'b0; tvalid = 1'b1;
    @(posedge clk);
    #1 tdata = 8'h42;
    @(negedge clk);
    chk("b2b_tready_first", {7'd0, tready}, 8'd0);
    chk("b2b_tx_wait", {7'd0, tx}, 8'd1);
    @(negedge clk);
    chk("b2b_tready_free", {7'd0, tready}, 8'd1);
    chk("b2b_bit", {7'd0, tx}, {7'd0, seq[0]});
    @(posedge clk);
    #1 tvalid = 1'b0;
    for (int k = 1; k < 2 * NB * CPB; k++) begin
      @(negedge clk);
      chk("b2b_bit", {7'd0, tx}, {7'd0, seq[k/CPB]});
      chk("b2b_busy", {7'd0, busy}, 8'd1);
      chk("b2b_done", {7'd0, done}, 8'd0);
      chk("b2b_tready", {7'd0, tready}, (k < NB * CPB) ? 8'd0 : 8'd1);
    end
    frame_end(1'b0);

    // tlast byte raises frame_done
    send(8'h0A, 1'b1);
    run_frame(mk(8'h0A));
    frame_end(1'b1);

    // async reset during data bit 3 of 0xF0 (line low there)
    send(8'hF0, 1'b0);
    for (int k = 0; k < 18; k++) @(negedge clk);
    chk("f0_bit3", {7'd0, tx}, 8'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tx", {7'd0, tx}, 8'd1);
    chk("async_tready", {7'd0, tready}, 8'd1);
    chk("async_busy", {7'd0, busy}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tx", {7'd0, tx}, 8'd1);
    send(8'h3C, 1'b1);
    run_frame(mk(8'h3C));
    frame_end(1'b1);

    // 0x07: odd number of ones, parity bit 1 in the parity build
    send(8'h07, 1'b0);
    run_frame(mk(8'h07));
    frame_end(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
